// File: rtl/gat_pkg.sv
// Shared constants and loader state type for the GAT BRAM loader.
package gat_pkg;

  localparam int TOP_WIDTH               = 32;
  localparam int H_DATA_DEPTH_DEFAULT    = 242101;
  localparam int NODE_INFO_DEPTH_DEFAULT = 13264;
  localparam int WEIGHT_DEPTH_DEFAULT    = 22928;

  typedef enum logic [2:0] {
    IDLE,
    LD_H,
    LD_NI,
    LD_WGT,
    DONE
  } loader_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gat_bram_wr_port.sv
// Registered write-port driver for one BRAM: a single-cycle ena/wea pulse
// per request, with din/addra holding their last written values.
module gat_bram_wr_port #(
  parameter int DW    = 32,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DW-1:0]    wr_data,
  input  logic [IDX_W-1:0] wr_idx,
  output logic [DW-1:0]    din,
  output logic             ena,
  output logic             wea,
  output logic [IDX_W+1:0] addra
);

  logic [DW-1:0]    din_q, din_d;
  logic [IDX_W+1:0] addra_q, addra_d;
  logic             ena_q, ena_d;

  always_comb begin
    din_d   = din_q;
    addra_d = addra_q;
    ena_d   = wr_en;
    if (wr_en) begin
      din_d   = wr_data;
      addra_d = {wr_idx, 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q   <= '0;
      addra_q <= '0;
      ena_q   <= 1'b0;
    end else begin
      din_q   <= din_d;
      addra_q <= addra_d;
      ena_q   <= ena_d;
    end
  end

  assign din   = din_q;
  assign ena   = ena_q;
  assign wea   = ena_q;
  assign addra = addra_q;

endmodule

// File: rtl/gat_bram_loader.sv
// Streams one load of H data, node info and weights into three BRAM write
// ports in that order. Optional running word sum: GAT_LOADER_CHECKSUM_EN.
module gat_bram_loader #(
  parameter int TOP_WIDTH       = gat_pkg::TOP_WIDTH,
  parameter int H_DATA_DEPTH    = gat_pkg::H_DATA_DEPTH_DEFAULT,
  parameter int NODE_INFO_DEPTH = gat_pkg::NODE_INFO_DEPTH_DEFAULT,
  parameter int WEIGHT_DEPTH    = gat_pkg::WEIGHT_DEPTH_DEFAULT,
  localparam int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
  localparam int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
  localparam int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [TOP_WIDTH-1:0]        s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [TOP_WIDTH-1:0]        h_data_bram_din,
  output logic                        h_data_bram_ena,
  output logic                        h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]    h_data_bram_addra,
  output logic [TOP_WIDTH-1:0]        h_node_info_bram_din,
  output logic                        h_node_info_bram_ena,
  output logic                        h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra,
  output logic [TOP_WIDTH-1:0]        wgt_bram_din,
  output logic                        wgt_bram_ena,
  output logic                        wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]    wgt_bram_addra,
  output logic                        h_data_bram_load_done,
  output logic                        h_node_info_bram_load_done,
  output logic                        wgt_bram_load_done,
`ifdef GAT_LOADER_CHECKSUM_EN
  output logic [TOP_WIDTH-1:0]        load_checksum,
`endif
  output logic                        busy
);

  import gat_pkg::*;

  localparam int CNT_W = max3(H_DATA_ADDR_W, NODE_INFO_ADDR_W, WEIGHT_ADDR_W);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_DATA_DEPTH - 1);
  localparam logic [CNT_W-1:0] NI_LAST  = CNT_W'(NODE_INFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] WGT_LAST = CNT_W'(WEIGHT_DEPTH - 1);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             h_done_q, h_done_d;
  logic             ni_done_q, ni_done_d;
  logic             wgt_done_q, wgt_done_d;
  logic             loading;
  logic             accept;
  logic             h_wr, ni_wr, wgt_wr;

  assign loading = (state_q == LD_H) || (state_q == LD_NI) || (state_q == LD_WGT);
  assign accept  = s_valid && loading;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    h_done_d   = h_done_q;
    ni_done_d  = ni_done_q;
    wgt_done_d = wgt_done_q;
    h_wr       = 1'b0;
    ni_wr      = 1'b0;
    wgt_wr     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LD_H;
          cnt_d      = '0;
          h_done_d   = 1'b0;
          ni_done_d  = 1'b0;
          wgt_done_d = 1'b0;
        end
      end
      LD_H: begin
        if (accept) begin
          h_wr = 1'b1;
          if (cnt_q == H_LAST) begin
            cnt_d    = '0;
            state_d  = LD_NI;
            h_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LD_NI: begin
        if (accept) begin
          ni_wr = 1'b1;
          if (cnt_q == NI_LAST) begin
            cnt_d     = '0;
            state_d   = LD_WGT;
            ni_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LD_WGT: begin
        if (accept) begin
          wgt_wr = 1'b1;
          if (cnt_q == WGT_LAST) begin
            cnt_d      = '0;
            state_d    = DONE;
            wgt_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Done flags are registered alongside the write ports so each rises with its last write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      h_done_q   <= 1'b0;
      ni_done_q  <= 1'b0;
      wgt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      h_done_q   <= h_done_d;
      ni_done_q  <= ni_done_d;
      wgt_done_q <= wgt_done_d;
    end
  end

  assign s_ready                    = loading;
  assign busy                       = loading;
  assign h_data_bram_load_done      = h_done_q;
  assign h_node_info_bram_load_done = ni_done_q;
  assign wgt_bram_load_done         = wgt_done_q;

  gat_bram_wr_port #(.DW(TOP_WIDTH), .IDX_W(H_DATA_ADDR_W)) u_h_port (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (h_wr),
    .wr_data (s_data),
    .wr_idx  (cnt_q[H_DATA_ADDR_W-1:0]),
    .din     (h_data_bram_din),
    .ena     (h_data_bram_ena),
    .wea     (h_data_bram_wea),
    .addra   (h_data_bram_addra)
  );

  gat_bram_wr_port #(.DW(TOP_WIDTH), .IDX_W(NODE_INFO_ADDR_W)) u_ni_port (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ni_wr),
    .wr_data (s_data),
    .wr_idx  (cnt_q[NODE_INFO_ADDR_W-1:0]),
    .din     (h_node_info_bram_din),
    .ena     (h_node_info_bram_ena),
    .wea     (h_node_info_bram_wea),
    .addra   (h_node_info_bram_addra)
  );

  gat_bram_wr_port #(.DW(TOP_WIDTH), .IDX_W(WEIGHT_ADDR_W)) u_wgt_port (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wgt_wr),
    .wr_data (s_data),
    .wr_idx  (cnt_q[WEIGHT_ADDR_W-1:0]),
    .din     (wgt_bram_din),
    .ena     (wgt_bram_ena),
    .wea     (wgt_bram_wea),
    .addra   (wgt_bram_addra)
  );

`ifdef GAT_LOADER_CHECKSUM_EN
  logic [TOP_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start && !loading) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_q + s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign load_checksum = sum_q;
`endif

endmodule

// File: tb/tb_gat_bram_loader.sv
// Directed bench for gat_bram_loader with small depths and a cycle-level model
// driven by cumulative word index within a load.
module tb_gat_bram_loader;

  localparam int W   = 32;
  localparam int HD  = 4;
  localparam int ND  = 2;
  localparam int WD  = 3;
  localparam int TOT = HD + ND + WD;
  localparam int HA  = $clog2(HD) + 2;
  localparam int NA  = $clog2(ND) + 2;
  localparam int WA  = $clog2(WD) + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  h_din, n_din, w_din;
  logic          h_ena, h_wea, n_ena, n_wea, w_ena, w_wea;
  logic [HA-1:0] h_addr;
  logic [NA-1:0] n_addr;
  logic [WA-1:0] w_addr;
  logic          h_done, n_done, w_done, busy;
`ifdef GAT_LOADER_CHECKSUM_EN
  logic [W-1:0]  load_checksum;
`endif

  always #5 clk = ~clk;

  gat_bram_loader #(
    .TOP_WIDTH(W), .H_DATA_DEPTH(HD), .NODE_INFO_DEPTH(ND), .WEIGHT_DEPTH(WD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea), .h_data_bram_addra(h_addr),
    .h_node_info_bram_din(n_din), .h_node_info_bram_ena(n_ena), .h_node_info_bram_wea(n_wea),
    .h_node_info_bram_addra(n_addr),
    .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addr),
    .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(n_done), .wgt_bram_load_done(w_done),
`ifdef GAT_LOADER_CHECKSUM_EN
    .load_checksum(load_checksum),
`endif
    .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: expected registered outputs derived from word position in the load.
  logic          m_loading;
  int            m_n;
  logic          e_h_en, e_n_en, e_w_en;
  logic [W-1:0]  e_h_din, e_n_din, e_w_din;
  logic [HA-1:0] e_h_addr;
  logic [NA-1:0] e_n_addr;
  logic [WA-1:0] e_w_addr;
  logic          e_h_done, e_n_done, e_w_done;
`ifdef GAT_LOADER_CHECKSUM_EN
  logic [W-1:0]  e_sum;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading <= 1'b0; m_n <= 0;
      e_h_en <= 1'b0; e_n_en <= 1'b0; e_w_en <= 1'b0;
      e_h_din <= '0; e_n_din <= '0; e_w_din <= '0;
      e_h_addr <= '0; e_n_addr <= '0; e_w_addr <= '0;
      e_h_done <= 1'b0; e_n_done <= 1'b0; e_w_done <= 1'b0;
`ifdef GAT_LOADER_CHECKSUM_EN
      e_sum <= '0;
`endif
    end else begin
      e_h_en <= 1'b0; e_n_en <= 1'b0; e_w_en <= 1'b0;
      if (m_loading && s_valid) begin
`ifdef GAT_LOADER_CHECKSUM_EN
        e_sum <= e_sum + s_data;
`endif
        if (m_n < HD) begin
          e_h_en <= 1'b1; e_h_din <= s_data; e_h_addr <= HA'(m_n * 4);
          if (m_n == HD - 1) e_h_done <= 1'b1;
        end else if (m_n < HD + ND) begin
          e_n_en <= 1'b1; e_n_din <= s_data; e_n_addr <= NA'((m_n - HD) * 4);
          if (m_n == HD + ND - 1) e_n_done <= 1'b1;
        end else begin
          e_w_en <= 1'b1; e_w_din <= s_data; e_w_addr <= WA'((m_n - HD - ND) * 4);
          if (m_n == TOT - 1) e_w_done <= 1'b1;
        end
        m_n <= m_n + 1;
        if (m_n + 1 == TOT) m_loading <= 1'b0;
      end else if (!m_loading && start) begin
        m_loading <= 1'b1; m_n <= 0;
        e_h_done <= 1'b0; e_n_done <= 1'b0; e_w_done <= 1'b0;
`ifdef GAT_LOADER_CHECKSUM_EN
        e_sum <= '0;
`endif
      end
    end
  end

  // Compare process plus write logs and busy-cycle counter for literal checks.
  logic [HA+W-1:0] log_h[$];
  logic [NA+W-1:0] log_n[$];
  logic [WA+W-1:0] log_w[$];
  int busy_cnt = 0;

  always @(posedge clk) begin
    #1;
    chk("s_ready", s_ready, m_loading);
    chk("busy", busy, m_loading);
    chk("h_ena", h_ena, e_h_en);
    chk("h_wea", h_wea, e_h_en);
    chk("h_din", h_din, e_h_din);
    chk("h_addr", h_addr, e_h_addr);
    chk("ni_ena", n_ena, e_n_en);
    chk("ni_wea", n_wea, e_n_en);
    chk("ni_din", n_din, e_n_din);
    chk("ni_addr", n_addr, e_n_addr);
    chk("wgt_ena", w_ena, e_w_en);
    chk("wgt_wea", w_wea, e_w_en);
    chk("wgt_din", w_din, e_w_din);
    chk("wgt_addr", w_addr, e_w_addr);
    chk("flags", {h_done, n_done, w_done}, {e_h_done, e_n_done, e_w_done});
`ifdef GAT_LOADER_CHECKSUM_EN
    chk("checksum", load_checksum, e_sum);
`endif
    if (busy) busy_cnt++;
    if (h_ena) log_h.push_back({h_addr, h_din});
    if (n_ena) log_n.push_back({n_addr, n_din});
    if (w_ena) log_w.push_back({w_addr, w_din});
  end

  logic [W-1:0] wdata [TOT];

  task automatic set_default_words();
    for (int i = 0; i < TOT; i++) wdata[i] = W'(32'h10 + i);
  endtask

  task automatic do_load(input int gap, input int start_at);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("flags_clr_after_start", {h_done, n_done, w_done}, 3'b000);
    for (int i = 0; i < TOT; i++) begin
      if (gap != 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = wdata[i];
      start   = (i == start_at);
      @(negedge clk);
      start = 1'b0;
    end
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Writes of a standard 0x10..0x18 load, checked against literal tables.
  task automatic check_logs(input string tag, input int oh, input int on, input int ow);
    chk({tag, "_h_count"}, W'(log_h.size() - oh), 4);
    chk({tag, "_ni_count"}, W'(log_n.size() - on), 2);
    chk({tag, "_wgt_count"}, W'(log_w.size() - ow), 3);
    for (int i = 0; i < 4 && oh + i < log_h.size(); i++)
      chk({tag, "_h_wr"}, W'(log_h[oh + i]), W'({HA'(i * 4), W'(32'h10 + i)}));
    for (int i = 0; i < 2 && on + i < log_n.size(); i++)
      chk({tag, "_ni_wr"}, W'(log_n[on + i]), W'({NA'(i * 4), W'(32'h14 + i)}));
    for (int i = 0; i < 3 && ow + i < log_w.size(); i++)
      chk({tag, "_wgt_wr"}, W'(log_w[ow + i]), W'({WA'(i * 4), W'(32'h16 + i)}));
    chk({tag, "_flags_end"}, {h_done, n_done, w_done}, 3'b111);
    chk({tag, "_busy_end"}, busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready_busy"}, {s_ready, busy}, 2'b00);
    chk({tag, "_en"}, {h_ena, h_wea, n_ena, n_wea, w_ena, w_wea}, 6'b0);
    chk({tag, "_h_din"}, h_din, '0);
    chk({tag, "_ni_din"}, n_din, '0);
    chk({tag, "_wgt_din"}, w_din, '0);
    chk({tag, "_addr"}, {h_addr, n_addr, w_addr}, '0);
    chk({tag, "_flags"}, {h_done, n_done, w_done}, 3'b000);
  endtask

  int oh, on, ow, b0;

  initial begin
    set_default_words();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Words offered in IDLE are ignored.
    s_valid = 1'b1; s_data = 32'hAAAA_5555;
    repeat (2) @(negedge clk);
    s_valid = 1'b0;

    oh = log_h.size(); on = log_n.size(); ow = log_w.size(); b0 = busy_cnt;
    do_load(0, -1);
    chk("t1_busy_cycles", W'(busy_cnt - b0), 9);
    check_logs("t1", oh, on, ow);

    // Words offered in DONE are ignored.
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    s_valid = 1'b0;

    oh = log_h.size(); on = log_n.size(); ow = log_w.size(); b0 = busy_cnt;
    do_load(1, -1);
    chk("t2_busy_cycles", W'(busy_cnt - b0), 18);
    check_logs("t2", oh, on, ow);

    oh = log_h.size(); on = log_n.size(); ow = log_w.size();
    do_load(0, 4);
    check_logs("t3", oh, on, ow);

    // Abort after two H words.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    s_valid = 1'b1; s_data = 32'h10; @(negedge clk);
    s_data = 32'h11; @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    chk_all_zero("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    oh = log_h.size(); on = log_n.size(); ow = log_w.size();
    do_load(0, -1);
    check_logs("t4", oh, on, ow);

    oh = log_h.size(); on = log_n.size(); ow = log_w.size();
    do_load(0, -1);
    check_logs("t5", oh, on, ow);

`ifdef GAT_LOADER_CHECKSUM_EN
    for (int i = 0; i < TOT; i++) wdata[i] = '0;
    wdata[0] = 32'hFFFF_FFFF;
    wdata[1] = 32'h0000_0002;
    do_load(0, -1);
    chk("t6_checksum", load_checksum, 32'h0000_0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gat_bram_loader.md
GAT_BRAM_LOADER -- requirements
Module: gat_bram_loader

Interface
REQ-001 SHALL have parameter TOP_WIDTH, default 32: stream word and BRAM data width.
REQ-002 SHALL have parameter H_DATA_DEPTH, default 242101: H data words per load.
REQ-003 SHALL have parameter NODE_INFO_DEPTH, default 13264: node-info words per load.
REQ-004 SHALL have parameter WEIGHT_DEPTH, default 22928: weight words per load.
REQ-005 SHALL derive localparams H_DATA_ADDR_W, NODE_INFO_ADDR_W and WEIGHT_ADDR_W as $clog2 of the matching depth.
REQ-006 Ports, with clock and reset first:
 clk  in  1  sole clock
 rst  in  1  asynchronous, active-high reset
 start  in  1  single-cycle load request
 s_data  in  TOP_WIDTH  input word stream
 s_valid  in  1  s_data valid
 s_ready  out  1  loader accepts a word
 h_data_bram_din/ena/wea  out  TOP_WIDTH/1/1  H data write port
 h_data_bram_addra  out  H_DATA_ADDR_W+2  byte address
 h_node_info_bram_din/ena/wea/addra  out  TOP_WIDTH/1/1/NODE_INFO_ADDR_W+2  node-info write port
 wgt_bram_din/ena/wea/addra  out  TOP_WIDTH/1/1/WEIGHT_ADDR_W+2  weight write port
 h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done  out  1  each segment complete
 busy  out  1  load in progress

Function
REQ-007 SHALL implement states IDLE, LD_H, LD_NI, LD_WGT and DONE.
REQ-008 SHALL go IDLE->LD_H, or DONE->LD_H, on start; start SHALL be ignored in LD_* states.
REQ-009 SHALL drive s_ready=1 only in LD_* states; a word SHALL be accepted when s_valid&&s_ready.
REQ-010 Each accepted word at index k of the current segment SHALL produce, next cycle, exactly one write on that segment's port: ena=wea=1, din=word, addra={k,2'b00}.
REQ-011 Non-target ports SHALL hold ena=wea=0; din and addra SHALL hold their last values.
REQ-012 The word counter SHALL reset to 0 at each segment change; it SHALL never wrap within a segment.
REQ-013 On acceptance of word DEPTH-1, SHALL advance LD_H->LD_NI->LD_WGT->DONE.
REQ-014 Each load_done flag SHALL rise in the same cycle as its segment's last write and SHALL stay high until the next accepted start.
REQ-015 Start in DONE SHALL clear all three load_done flags in the next cycle.
REQ-016 busy SHALL be 1 exactly in LD_* states.
REQ-017 s_valid low SHALL stall with no write and no counter change; there SHALL be no bubble when s_valid is held high.
REQ-018 Words presented in IDLE/DONE SHALL be ignored (s_ready=0).

Reset
REQ-019 rst SHALL asynchronously force IDLE, counter 0, and every output 0, including din and addra.
REQ-020 rst mid-load SHALL abort with no further writes; the next load SHALL restart at LD_H address 0.

Configuration
REQ-021 With GAT_LOADER_CHECKSUM_EN defined, SHALL add output load_checksum[TOP_WIDTH-1:0]: the modulo-2^TOP_WIDTH sum of all words accepted since the last start, cleared on start and by rst.
REQ-022 Without GAT_LOADER_CHECKSUM_EN, the load_checksum port and its logic SHALL be absent.

Structure
REQ-023 gat_pkg SHALL hold TOP_WIDTH, the three default depths and the loader state enum.
REQ-024 SHALL instantiate sub-module gat_bram_wr_port three times; it registers the din/ena/wea/addra driver for one port.

Verification (override H_DATA_DEPTH=4, NODE_INFO_DEPTH=2, WEIGHT_DEPTH=3)
REQ-025 start, then 9 words 0x10..0x18 with s_valid held high -> H writes at 0x0,0x4,0x8,0xC with 0x10..0x13; NI at 0x0,0x4 with 0x14,0x15; WGT at 0x0,0x4,0x8 with 0x16..0x18; flags rise in order; busy=0 after 9 words.
REQ-026 s_valid toggled every other cycle -> same writes, no duplicates, 18-cycle load.
REQ-027 start pulsed during LD_NI -> ignored; sequence unaffected.
REQ-028 rst after 2 H words, then start and 9 words -> all outputs 0 during rst; rewrite from H address 0x0.
REQ-029 start in DONE -> flags 0 next cycle; second 9-word load repeats REQ-025.
REQ-030 With GAT_LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x2 followed by zeros -> load_checksum=0x00000001.
